mem_bus_bridge: RTL

- Sits directly downstream of the 5-stage core's data-memory port (mem_ren/mem_wen/mem_addr/mem_dout/mem_din).
- Converts that single-cycle access into a req/ack handshake toward a multi-cycle data memory or bus.
- Drives mem_stall back to the pipeline controller so the MEM stage freezes until the access completes.
- Adds a bounded ack timeout with a sticky error flag.

---
 rtl/mem_bus_bridge.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: turns the core's single-cycle data-memory access into a
// req/ack handshake toward a multi-cycle memory or bus. It stalls the MEM
// stage while an access is outstanding and bounds the wait with a timeout
// that raises a sticky error flag.
//
// Optional feature: define BRIDGE_RDATA_BYPASS_EN to forward bus_rdata
// combinationally to mem_din in the acknowledging cycle of a read. That read
// then skips the DONE cycle. Writes and timeouts still pass through DONE.
module mem_bus_bridge #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    TIMEOUT    = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_stall,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_ack,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    // The wait counter is 8 bits wide, so TIMEOUT must lie in 1..255.
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  err_q, err_d;
    logic                  rdata_bypass;

    // Next-state logic, captured request fields, read data and stall.
    always_comb begin
        // NOTE: every signal driven here gets a default before the case, so
        // no path can leave one unassigned and infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        din_d        = din_q;
        err_d        = err_q;
        mem_stall    = 1'b0;
        rdata_bypass = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_ren || mem_wen) begin
                    // Stall rises with the request itself. A write wins
                    // over a simultaneous read.
                    mem_stall = 1'b1;
                    addr_d    = mem_addr;
                    wdata_d   = mem_dout;
                    we_d      = mem_wen;
                    cnt_d     = 8'd0;
                    state_d   = REQ;
                end
            end

            REQ: begin
                mem_stall = 1'b1;
                if (bus_ack) begin
                    if (!we_q) begin
                        din_d = bus_rdata;
                    end
                    state_d = DONE;
`ifdef BRIDGE_RDATA_BYPASS_EN
                    if (!we_q) begin
                        // The read data goes straight to the core and the
                        // pipeline advances now, so DONE is skipped.
                        rdata_bypass = 1'b1;
                        mem_stall    = 1'b0;
                        state_d      = IDLE;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TIMEOUT_CNT) begin
                        // Give up after TIMEOUT unacknowledged REQ cycles.
                        state_d = DONE;
                        err_d   = 1'b1;
                        if (!we_q) begin
                            din_d = ERR_DATA;
                        end
                    end
                end
            end

            DONE: begin
                // The pipeline advances at this edge. The core's request,
                // which is still present, is deliberately ignored.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            din_q   <= din_d;
            err_q   <= err_d;
        end
    end

    // bus_req is decoded from the state register, so an asynchronous reset
    // drops it at once and any late ack finds the FSM already in IDLE.
    assign bus_req     = (state_q == REQ);
    assign bus_we      = we_q;
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;
    assign timeout_err = err_q;
    assign mem_din     = rdata_bypass ? bus_rdata : din_q;

endmodule
